// File: rtl/rotate_amount_detector_if.sv
// rotate_amount_detector_if: request/result bundle between a requester and the rotate amount detector
interface rotate_amount_detector_if #(
  parameter int WIDTH = 16,
  parameter int AMT_W = 4
);
  logic             start;
  logic [WIDTH-1:0] orig;
  logic [WIDTH-1:0] rotated;
  logic             dir;
  logic             busy;
  logic             done;
  logic             found;
  logic [AMT_W-1:0] amount;
  modport master (output start, orig, rotated, dir, input busy, done, found, amount);
  modport slave (input start, orig, rotated, dir, output busy, done, found, amount);
endinterface

// File: rtl/rotate_amount_detector.sv
// rotate_amount_detector: iterative search for the smallest rotation mapping orig to rotated; ROT_DET_EARLY_EXIT_EN ends the search on the first match
module rotate_amount_detector #(
  parameter int WIDTH = 16,
  parameter int AMT_W = 4
) (
  input logic clk,
  input logic rst,
  rotate_amount_detector_if.slave bus
);
  typedef enum logic [1:0] {IDLE, SEARCH, DONE} state_t;
  state_t           state_q, state_d;
  logic [WIDTH-1:0] work_q, work_d, target_q, target_d;
  logic             dir_q, dir_d, found_q, found_d;
  logic [AMT_W-1:0] cand_q, cand_d, amount_q, amount_d;
  logic             accept, match, last, finish;
  assign accept = bus.start && state_q != SEARCH;
  assign match  = work_q == target_q;
  assign last   = cand_q == AMT_W'(WIDTH - 1);
`ifdef ROT_DET_EARLY_EXIT_EN
  assign finish = last || match;
`else
  assign finish = last;
`endif
  // next state: load on accepted start, rotate and record first match while searching
  always_comb begin
    state_d  = state_q;
    work_d   = work_q;
    target_d = target_q;
    dir_d    = dir_q;
    cand_d   = cand_q;
    found_d  = found_q;
    amount_d = amount_q;
    if (accept) begin
      state_d  = SEARCH;
      work_d   = bus.orig;
      target_d = bus.rotated;
      dir_d    = bus.dir;
      cand_d   = '0;
      found_d  = 1'b0;
      amount_d = '0;
    end else if (state_q == SEARCH) begin
      found_d  = found_q | match;
      amount_d = (match && !found_q) ? cand_q : amount_q;
      work_d   = dir_q ? {work_q[0], work_q[WIDTH-1:1]} : {work_q[WIDTH-2:0], work_q[WIDTH-1]};
      cand_d   = cand_q + 1'b1;
      state_d  = finish ? DONE : SEARCH;
    end else if (state_q == DONE) begin
      state_d = IDLE;
    end
  end
  // state and working registers; reset aborts any search in progress
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      work_q   <= '0;
      target_q <= '0;
      dir_q    <= 1'b0;
      cand_q   <= '0;
      found_q  <= 1'b0;
      amount_q <= '0;
    end else begin
      state_q  <= state_d;
      work_q   <= work_d;
      target_q <= target_d;
      dir_q    <= dir_d;
      cand_q   <= cand_d;
      found_q  <= found_d;
      amount_q <= amount_d;
    end
  end
  assign bus.busy   = state_q == SEARCH;
  assign bus.done   = state_q == DONE;
  assign bus.found  = found_q;
  assign bus.amount = amount_q;
endmodule

// File: tb/tb_rotate_amount_detector.sv
// tb_rotate_amount_detector: directed scoreboard bench for rotate_amount_detector; honours ROT_DET_EARLY_EXIT_EN
module tb_rotate_amount_detector;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  rotate_amount_detector_if bus ();
  rotate_amount_detector dut (.clk(clk), .rst(rst), .bus(bus));
  typedef struct {
    logic       f;
    logic [3:0] a;
    int         lat;
  } exp_t;
  exp_t sb[$];
  int checks = 0;
  int failures = 0;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic drive(input logic [15:0] o, input logic [15:0] r, input logic d, input logic s);
    bus.orig    = o;
    bus.rotated = r;
    bus.dir     = d;
    bus.start   = s;
  endtask
  task automatic push_exp(input logic f, input logic [3:0] a);
    exp_t e;
    e.f = f;
    e.a = a;
`ifdef ROT_DET_EARLY_EXIT_EN
    e.lat = f ? int'(a) + 1 : 16;
`else
    e.lat = 16;
`endif
    sb.push_back(e);
  endtask
  task automatic issue(input logic [15:0] o, input logic [15:0] r, input logic d, input logic f, input logic [3:0] a);
    drive(o, r, d, 1'b1);
    push_exp(f, a);
  endtask
  task automatic wait_check(input string tag, input logic keep, input logic [15:0] no, input logic [15:0] nr,
                            input logic nd, input logic post);
    exp_t e;
    int lat;
    @(posedge clk);
    #1;
    drive(no, nr, nd, keep);
    chk({tag, "_busy"}, bus.busy, 1);
    lat = 0;
    while (!bus.done && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
    end
    e = sb.pop_front();
    chk({tag, "_latency"}, lat, e.lat);
    chk({tag, "_found"}, bus.found, e.f);
    chk({tag, "_amount"}, bus.amount, e.a);
    chk({tag, "_busy_at_done"}, bus.busy, 0);
    if (post) begin
      @(posedge clk);
      #1;
      chk({tag, "_done_pulse"}, bus.done, 0);
      chk({tag, "_found_hold"}, bus.found, e.f);
      chk({tag, "_amount_hold"}, bus.amount, e.a);
    end
  endtask
  initial begin
    bit saw_done;
    drive(16'h0, 16'h0, 1'b0, 1'b0);
    #12;
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_found", bus.found, 0);
    chk("rst_amount", bus.amount, 0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    issue(16'h0001, 16'h0008, 1'b0, 1'b1, 4'd3);
    wait_check("left", 1'b0, 16'h0001, 16'h0008, 1'b0, 1'b1);
    issue(16'h8001, 16'hC000, 1'b1, 1'b1, 4'd1);
    wait_check("right", 1'b0, 16'h8001, 16'hC000, 1'b1, 1'b1);
    issue(16'h8001, 16'hC000, 1'b0, 1'b1, 4'd15);
    wait_check("left15", 1'b0, 16'h8001, 16'hC000, 1'b0, 1'b1);
    issue(16'hAAAA, 16'h5555, 1'b0, 1'b1, 4'd1);
    wait_check("periodic", 1'b0, 16'hAAAA, 16'h5555, 1'b0, 1'b1);
    issue(16'hFFFF, 16'hFFFF, 1'b0, 1'b1, 4'd0);
    wait_check("ones", 1'b0, 16'hFFFF, 16'hFFFF, 1'b0, 1'b1);
    issue(16'h1234, 16'h1235, 1'b0, 1'b0, 4'd0);
    wait_check("nomatch", 1'b0, 16'h1234, 16'h1235, 1'b0, 1'b1);
    repeat (3) @(posedge clk);
    #1;
    chk("nomatch_found_idle", bus.found, 0);
    issue(16'h0001, 16'h0008, 1'b0, 1'b1, 4'd3);
    push_exp(1'b1, 4'd4);
    wait_check("b2b_first", 1'b1, 16'h00F0, 16'h0F00, 1'b0, 1'b0);
    wait_check("b2b_second", 1'b0, 16'h00F0, 16'h0F00, 1'b0, 1'b1);
    drive(16'h0001, 16'h8000, 1'b0, 1'b1);
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    chk("abort_busy_before", bus.busy, 1);
    rst = 1'b1;
    #1;
    chk("abort_busy", bus.busy, 0);
    chk("abort_done", bus.done, 0);
    chk("abort_found", bus.found, 0);
    chk("abort_amount", bus.amount, 0);
    @(negedge clk);
    rst = 1'b0;
    saw_done = 1'b0;
    repeat (20) begin
      @(posedge clk);
      #1;
      if (bus.done) saw_done = 1'b1;
    end
    chk("abort_no_done", saw_done, 0);
    issue(16'h0001, 16'h0008, 1'b0, 1'b1, 4'd3);
    wait_check("after_abort", 1'b0, 16'h0001, 16'h0008, 1'b0, 1'b1);
    chk("scoreboard_empty", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
